// File: rtl/sd_init_seq_if.sv
// Command-stage handshake bundle between the SD init sequencer
// and the SPI command/response stage.
interface sd_init_seq_if;
    logic [5:0]  cmdIndex;
    logic [31:0] cmdArgument;
    logic        cmdStart;
    logic        cmdBusy;
    logic        cmdFinish;
    logic [39:0] cmdResponse;

    modport master (
        output cmdIndex,
        output cmdArgument,
        output cmdStart,
        input  cmdBusy,
        input  cmdFinish,
        input  cmdResponse
    );

    modport slave (
        input  cmdIndex,
        input  cmdArgument,
        input  cmdStart,
        output cmdBusy,
        output cmdFinish,
        output cmdResponse
    );
endinterface

// File: rtl/sd_init_seq.sv
// SPI-mode SD card power-up / init sequencer.
// Walks CMD0, CMD8, CMD55+ACMD41 loop, CMD58 and classifies the card.
module sd_init_seq #(
    parameter int PWRUP_CYCLES = 80,
    parameter int CMD0_RETRIES = 8,
    parameter int ACMD41_MAX   = 1000,
    parameter int GAP_CYCLES   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    sd_init_seq_if.master cmd,
    output logic          csN_o,
    output logic          isBusy_o,
    output logic          isReady_o,
    output logic          isError_o,
    output logic [2:0]    errorCode_o,
    output logic          isSDv2_o,
    output logic          isHC_o
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_PWRUP   = 4'd1;
    localparam logic [3:0] S_GAP     = 4'd2;
    localparam logic [3:0] S_ISSUE   = 4'd3;
    localparam logic [3:0] S_WAIT    = 4'd4;
    localparam logic [3:0] S_RELEASE = 4'd5;
    localparam logic [3:0] S_EVAL    = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERROR   = 4'd8;

    localparam logic [2:0] C_CMD0   = 3'd0;
    localparam logic [2:0] C_CMD8   = 3'd1;
    localparam logic [2:0] C_CMD55  = 3'd2;
    localparam logic [2:0] C_ACMD41 = 3'd3;
    localparam logic [2:0] C_CMD58  = 3'd4;

    localparam int PWR_W = $clog2(PWRUP_CYCLES) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam int RTY_W = $clog2(CMD0_RETRIES) + 1;
    localparam int ACM_W = $clog2(ACMD41_MAX) + 1;

    logic [3:0]       state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [PWR_W-1:0] pwr_q, pwr_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [ACM_W-1:0] acmd_q, acmd_d;
    logic             start_q;
    logic [5:0]       idx_q, idx_d;
    logic [31:0]      arg_q, arg_d;
    logic             go_q, go_d;
    logic [7:0]       r1_q, r1_d;
    logic             pat_q, pat_d;
    logic             ccs_q, ccs_d;
    logic             cs_q, cs_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [2:0]       code_q, code_d;
    logic             v2_q, v2_d;
    logic             hc_q, hc_d;

    logic             accept;
    logic             go_gap, fail, done;
    logic [2:0]       nxt, fcode;

    // Only R1, the CMD8 echo pattern and the OCR CCS bit matter here.
    logic unused_resp;
    assign unused_resp = ^{cmd.cmdResponse[31], cmd.cmdResponse[29:12]};

    assign cmd.cmdIndex    = idx_q;
    assign cmd.cmdArgument = arg_q;
    assign cmd.cmdStart    = go_q;
    assign csN_o           = cs_q;
    assign isBusy_o        = busy_q;
    assign isReady_o       = ready_q;
    assign isError_o       = err_q;
    assign errorCode_o     = code_q;
    assign isSDv2_o        = v2_q;
    assign isHC_o          = hc_q;

    assign accept = start_i && !start_q &&
                    (state_q == S_IDLE || state_q == S_DONE ||
                     state_q == S_ERROR);

    // Next-state logic: sequencing, command issue and response evaluation.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        pwr_d   = pwr_q;
        gap_d   = gap_q;
        retry_d = retry_q;
        acmd_d  = acmd_q;
        idx_d   = idx_q;
        arg_d   = arg_q;
        go_d    = go_q;
        r1_d    = r1_q;
        pat_d   = pat_q;
        ccs_d   = ccs_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        err_d   = err_q;
        code_d  = code_q;
        v2_d    = v2_q;
        hc_d    = hc_q;
        go_gap  = 1'b0;
        fail    = 1'b0;
        done    = 1'b0;
        nxt     = pend_q;
        fcode   = 3'd0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept) begin
                    state_d = S_PWRUP;
                    pend_d  = C_CMD0;
                    pwr_d   = '0;
                    retry_d = '0;
                    acmd_d  = '0;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    code_d  = 3'd0;
                    v2_d    = 1'b0;
                    hc_d    = 1'b0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    go_d    = 1'b0;
                end
            end
            S_PWRUP: begin
                if (pwr_q == PWR_W'(PWRUP_CYCLES - 1)) begin
                    cs_d   = 1'b0;
                    go_gap = 1'b1;
                    nxt    = C_CMD0;
                end else begin
                    pwr_d = pwr_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                    arg_d   = 32'h0;
                    case (pend_q)
                        C_CMD8: begin
                            idx_d = 6'd8;
                            arg_d = 32'h0000_01AA;
                        end
                        C_CMD55: idx_d = 6'd55;
                        C_ACMD41: begin
                            idx_d = 6'd41;
                            arg_d = v2_q ? 32'h4000_0000 : 32'h0;
                        end
                        C_CMD58: idx_d = 6'd58;
                        default: idx_d = 6'd0;
                    endcase
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (!cmd.cmdBusy && !cmd.cmdFinish) begin
                    go_d    = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cmd.cmdFinish) begin
                    r1_d    = cmd.cmdResponse[39:32];
                    pat_d   = cmd.cmdResponse[11:0] == 12'h1AA;
                    ccs_d   = cmd.cmdResponse[30];
                    go_d    = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!cmd.cmdFinish) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                case (pend_q)
                    C_CMD0: begin
                        if (r1_q == 8'h01) begin
                            go_gap = 1'b1;
                            nxt    = C_CMD8;
                        end else if (retry_q == RTY_W'(CMD0_RETRIES - 1)) begin
                            fail  = 1'b1;
                            fcode = 3'd1;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            go_gap  = 1'b1;
                            nxt     = C_CMD0;
                        end
                    end
                    C_CMD8: begin
                        if (r1_q == 8'h01 && pat_q) begin
                            v2_d   = 1'b1;
                            go_gap = 1'b1;
                            nxt    = C_CMD55;
                        end else if (!r1_q[7] && r1_q[2]) begin
                            // Illegal-command reply: legacy v1 card.
                            v2_d   = 1'b0;
                            go_gap = 1'b1;
                            nxt    = C_CMD55;
                        end else begin
                            fail  = 1'b1;
                            fcode = 3'd2;
                        end
                    end
                    C_CMD55: begin
                        if ((r1_q & 8'hFE) == 8'h00) begin
                            go_gap = 1'b1;
                            nxt    = C_ACMD41;
                        end else begin
                            fail  = 1'b1;
                            fcode = 3'd3;
                        end
                    end
                    C_ACMD41: begin
                        if (r1_q == 8'h00) begin
                            if (v2_q) begin
                                go_gap = 1'b1;
                                nxt    = C_CMD58;
                            end else begin
                                done = 1'b1;
                            end
                        end else if (r1_q == 8'h01) begin
                            if (acmd_q == ACM_W'(ACMD41_MAX - 1)) begin
                                fail  = 1'b1;
                                fcode = 3'd3;
                            end else begin
                                acmd_d = acmd_q + 1'b1;
                                go_gap = 1'b1;
                                nxt    = C_CMD55;
                            end
                        end else begin
                            fail  = 1'b1;
                            fcode = 3'd3;
                        end
                    end
                    C_CMD58: begin
                        if (r1_q == 8'h00) begin
                            hc_d = ccs_q;
                            done = 1'b1;
                        end else begin
                            fail  = 1'b1;
                            fcode = 3'd4;
                        end
                    end
                    default: begin
                        fail  = 1'b1;
                        fcode = 3'd0;
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        if (go_gap) begin
            state_d = S_GAP;
            gap_d   = '0;
            pend_d  = nxt;
        end
        if (fail) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            code_d  = fcode;
            busy_d  = 1'b0;
            cs_d    = 1'b1;
            go_d    = 1'b0;
        end
        if (done) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            cs_d    = 1'b0;
        end
    end

    // State registers; reset drops cmdStart at once, even mid-command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= C_CMD0;
            pwr_q   <= '0;
            gap_q   <= '0;
            retry_q <= '0;
            acmd_q  <= '0;
            start_q <= 1'b0;
            idx_q   <= 6'd0;
            arg_q   <= 32'h0;
            go_q    <= 1'b0;
            r1_q    <= 8'h00;
            pat_q   <= 1'b0;
            ccs_q   <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
            v2_q    <= 1'b0;
            hc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pwr_q   <= pwr_d;
            gap_q   <= gap_d;
            retry_q <= retry_d;
            acmd_q  <= acmd_d;
            start_q <= start_i;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
            go_q    <= go_d;
            r1_q    <= r1_d;
            pat_q   <= pat_d;
            ccs_q   <= ccs_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            code_q  <= code_d;
            v2_q    <= v2_d;
            hc_q    <= hc_d;
        end
    end
endmodule

// File: tb/tb_sd_init_seq.sv
// Scoreboard bench for sd_init_seq with a behavioural card/cmd-stage model.
`timescale 1ns/1ps
module tb_sd_init_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    sd_init_seq_if cmd_if ();

    logic       csN, isBusy, isReady, isError, isSDv2, isHC;
    logic [2:0] errorCode;

    sd_init_seq #(.ACMD41_MAX(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .cmd         (cmd_if),
        .csN_o       (csN),
        .isBusy_o    (isBusy),
        .isReady_o   (isReady),
        .isError_o   (isError),
        .errorCode_o (errorCode),
        .isSDv2_o    (isSDv2),
        .isHC_o      (isHC)
    );

    int checks = 0;
    int failures = 0;

    logic [37:0] exp_cmd[$];
    logic [7:0]  exp_res[$];
    logic [37:0] e_cmd, g_cmd;
    logic [7:0]  e_res, g_res;
    logic        prev_go = 1'b0;
    logic        prev_busy = 1'b0;

    // card behaviour knobs
    logic cmd0_to = 1'b0;
    logic v1card = 1'b0;
    int   ok_after = 0;
    int   acmd_n = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_cmd(input int idx, input logic [31:0] arg);
        exp_cmd.push_back({6'(idx), arg});
    endtask

    task automatic push_pairs(input int n, input logic [31:0] arg41);
        for (int i = 0; i < n; i++) begin
            push_cmd(55, 32'h0);
            push_cmd(41, arg41);
        end
    endtask

    task automatic push_v2hc();
        push_cmd(0, 32'h0);
        push_cmd(8, 32'h1AA);
        push_pairs(4, 32'h4000_0000);
        push_cmd(58, 32'h0);
        exp_res.push_back(8'b1_0_000_1_1_0);
    endtask

    task automatic push_v1();
        push_cmd(0, 32'h0);
        push_cmd(8, 32'h1AA);
        push_pairs(1, 32'h0);
        exp_res.push_back(8'b1_0_000_0_0_0);
    endtask

    task automatic setup(input logic to, input logic v1, input int ok);
        cmd0_to  = to;
        v1card   = v1;
        ok_after = ok;
        acmd_n   = 0;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic wait_busy(input string nm);
        int n;
        n = 0;
        while (!isBusy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_busy_rise"}, isBusy, 1);
    endtask

    task automatic wait_done(input string nm);
        int n;
        wait_busy(nm);
        n = 0;
        while (isBusy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_busy_fall"}, isBusy, 0);
    endtask

    // Behavioural command stage plus card.
    initial begin
        cmd_if.cmdBusy     = 1'b0;
        cmd_if.cmdFinish   = 1'b0;
        cmd_if.cmdResponse = '0;
        forever begin
            @(negedge clk);
            if (reset && cmd_if.cmdStart && !cmd_if.cmdBusy &&
                !cmd_if.cmdFinish) begin
                cmd_if.cmdBusy = 1'b1;
                repeat (3) @(negedge clk);
                case (cmd_if.cmdIndex)
                    6'd0: cmd_if.cmdResponse = cmd0_to ?
                        40'hFF_FFFF_FFFF : {8'h01, 32'h0};
                    6'd8: cmd_if.cmdResponse = v1card ?
                        {8'h05, 32'h0} : {8'h01, 32'h0000_01AA};
                    6'd55: cmd_if.cmdResponse = {8'h01, 32'h0};
                    6'd41: begin
                        cmd_if.cmdResponse = (acmd_n < ok_after) ?
                            {8'h01, 32'h0} : {8'h00, 32'h0};
                        acmd_n++;
                    end
                    6'd58: cmd_if.cmdResponse = {8'h00, 32'hC0FF_8000};
                    default: cmd_if.cmdResponse = 40'hFF_FFFF_FFFF;
                endcase
                cmd_if.cmdFinish = 1'b1;
                for (int k = 0; k < 20 && cmd_if.cmdStart; k++)
                    @(negedge clk);
                cmd_if.cmdFinish = 1'b0;
                cmd_if.cmdBusy   = 1'b0;
            end
        end
    end

    // Monitor: command issues and end-of-sequence status.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_go   = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (cmd_if.cmdStart && !prev_go) begin
                    g_cmd = {cmd_if.cmdIndex, cmd_if.cmdArgument};
                    checks++;
                    if (exp_cmd.size() == 0) begin
                        failures++;
                        $display("FAIL cmd_extra got idx=%0d arg=%h required none",
                                 g_cmd[37:32], g_cmd[31:0]);
                    end else begin
                        e_cmd = exp_cmd.pop_front();
                        if (g_cmd !== e_cmd) begin
                            failures++;
                            $display("FAIL cmd_seq got idx=%0d arg=%h required idx=%0d arg=%h",
                                     g_cmd[37:32], g_cmd[31:0],
                                     e_cmd[37:32], e_cmd[31:0]);
                        end
                    end
                end
                if (prev_busy && !isBusy) begin
                    g_res = {isReady, isError, errorCode, isSDv2, isHC, csN};
                    checks++;
                    if (exp_res.size() == 0) begin
                        failures++;
                        $display("FAIL res_extra got=%b required none", g_res);
                    end else begin
                        e_res = exp_res.pop_front();
                        if (g_res !== e_res) begin
                            failures++;
                            $display("FAIL result got=%b required=%b (rdy,err,code,v2,hc,csN)",
                                     g_res, e_res);
                        end
                    end
                end
                prev_go   = cmd_if.cmdStart;
                prev_busy = isBusy;
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_csN", csN, 1);
        chk("rst_busy", isBusy, 0);
        chk("rst_ready", isReady, 0);
        chk("rst_error", isError, 0);
        chk("rst_code", errorCode, 0);
        chk("rst_cmdStart", cmd_if.cmdStart, 0);
        chk("rst_cmdIndex", cmd_if.cmdIndex, 0);
        chk("rst_cmdArg", cmd_if.cmdArgument, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: v2 high-capacity card
        setup(1'b0, 1'b0, 3);
        push_v2hc();
        kick();
        wait_busy("s1");
        n = 0;
        while (csN && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pwrup_csN_cycles", n, 80);
        wait_done("s1");
        chk("s1_acmd41_count", acmd_n, 4);

        // 2: v1 card
        setup(1'b0, 1'b1, 0);
        push_v1();
        kick();
        wait_done("s2");
        chk("s2_acmd41_count", acmd_n, 1);

        // 3: CMD0 never answers
        setup(1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) push_cmd(0, 32'h0);
        exp_res.push_back(8'b0_1_001_0_0_1);
        kick();
        wait_done("s3");

        // 4: ACMD41 stays idle forever
        setup(1'b0, 1'b0, 1000);
        push_cmd(0, 32'h0);
        push_cmd(8, 32'h1AA);
        push_pairs(5, 32'h4000_0000);
        exp_res.push_back(8'b0_1_011_1_0_1);
        kick();
        wait_done("s4");
        chk("s4_acmd41_count", acmd_n, 5);

        // 5: reset during CMD8, then full rerun
        setup(1'b0, 1'b0, 3);
        push_cmd(0, 32'h0);
        push_cmd(8, 32'h1AA);
        kick();
        n = 0;
        while (!(cmd_if.cmdStart && cmd_if.cmdIndex == 6'd8) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("s5_cmd8_seen", cmd_if.cmdStart, 1);
        #1 reset = 1'b0;
        #1;
        chk("s5_cmdStart", cmd_if.cmdStart, 0);
        chk("s5_csN", csN, 1);
        chk("s5_busy", isBusy, 0);
        chk("s5_cmdIndex", cmd_if.cmdIndex, 0);
        chk("s5_cmdArg", cmd_if.cmdArgument, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        setup(1'b0, 1'b0, 3);
        push_v2hc();
        kick();
        wait_done("s5");

        // 6: start held / retoggled while busy, then a clean rerun
        setup(1'b0, 1'b1, 0);
        push_v1();
        kick();
        wait_busy("s6a");
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        wait_done("s6a");
        repeat (5) @(negedge clk);
        chk("s6_hold_ready", isReady, 1);
        chk("s6_hold_busy", isBusy, 0);
        setup(1'b0, 1'b1, 0);
        push_v1();
        kick();
        wait_done("s6b");

        repeat (5) @(negedge clk);
        chk("cmd_queue_empty", exp_cmd.size(), 0);
        chk("res_queue_empty", exp_res.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
